// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, field positions and field widths.
// Used by both the instruction decoder and the program-load encoder.
package isa_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam int FIELD_W   = 5;
    localparam int OP_LSB    = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALU_LSB   = 2;

    localparam int IMM_W = 17;
    localparam int TGT_W = 27;

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packer with immediate/target range check.
// Out-of-range bundles pack to an all-zero word (nop).
module instr_pack
    import isa_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  shamt,
    input  logic [4:0]  alu_op,
    input  logic [31:0] imm,
    input  logic [31:0] target,
    output logic [31:0] word,
    output logic        range_err
);

    logic is_i;
    logic is_s;
    logic is_b;
    logic is_jr;
    logic is_j;
    logic imm_bad;
    logic tgt_bad;

    assign is_i  = (op == OP_ADDI) || (op == OP_LW);
    assign is_s  = (op == OP_SW);
    assign is_b  = (op == OP_BNE) || (op == OP_BLT);
    assign is_jr = (op == OP_JR);
    assign is_j  = (op == OP_J) || (op == OP_JAL) ||
                   (op == OP_BEX) || (op == OP_SETX);

    // imm must be the sign extension of its low IMM_W bits
    assign imm_bad = imm[31:IMM_W-1] != {(33-IMM_W){imm[IMM_W-1]}};
    assign tgt_bad = |target[31:TGT_W];

    // pack fields by format; unknown opcodes fall back to R-type
    always_comb begin
        word      = '0;
        range_err = 1'b0;
        word[OP_LSB +: FIELD_W] = op;
        unique case (1'b1)
            is_i: begin
                word[RD_LSB +: FIELD_W] = rd;
                word[RS_LSB +: FIELD_W] = rs;
                word[IMM_W-1:0]         = imm[IMM_W-1:0];
                range_err               = imm_bad;
            end
            is_s: begin
                word[RD_LSB +: FIELD_W] = rt;
                word[RS_LSB +: FIELD_W] = rs;
                word[IMM_W-1:0]         = imm[IMM_W-1:0];
                range_err               = imm_bad;
            end
            is_b: begin
                word[RD_LSB +: FIELD_W] = rs;
                word[RS_LSB +: FIELD_W] = rt;
                word[IMM_W-1:0]         = imm[IMM_W-1:0];
                range_err               = imm_bad;
            end
            is_jr: begin
                word[RD_LSB +: FIELD_W] = rs;
            end
            is_j: begin
                word[TGT_W-1:0] = target[TGT_W-1:0];
                range_err       = tgt_bad;
            end
            default: begin
                word[RD_LSB +: FIELD_W]    = rd;
                word[RS_LSB +: FIELD_W]    = rs;
                word[RT_LSB +: FIELD_W]    = rt;
                word[SHAMT_LSB +: FIELD_W] = shamt;
                word[ALU_LSB +: FIELD_W]   = alu_op;
            end
        endcase
        if (range_err) begin
            word = '0;
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts field bundles, encodes them and writes
// sequential IMEM words one cycle after each handshake.
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        shamt,
    input  logic [4:0]        alu_op,
    input  logic [31:0]       imm,
    input  logic [31:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   instr_count
);

    localparam int CW = ADDR_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } load_state_t;

    load_state_t       state;
    logic [ADDR_W-1:0] nxt_addr;
    logic [CW-1:0]     issued;
    logic              hs;
    logic              fill;
    logic [31:0]       pk_word;
    logic              pk_err;

    instr_pack u_pack (
        .op       (op),
        .rd       (rd),
        .rs       (rs),
        .rt       (rt),
        .shamt    (shamt),
        .alu_op   (alu_op),
        .imm      (imm),
        .target   (target),
        .word     (pk_word),
        .range_err(pk_err)
    );

    // words written plus the one in flight in the output register
    assign issued   = CW'(instr_count) + CW'(imem_we);
    assign in_ready = (state == ST_RUN) && (issued < CW'(DEPTH));
    assign hs       = in_valid && in_ready;
    assign fill     = (issued + CW'(1)) == CW'(DEPTH);

    // load FSM, address counter and registered IMEM write port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            nxt_addr    <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_data   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            instr_count <= '0;
        end else begin
            imem_we <= hs;
            if (hs) begin
                imem_addr <= nxt_addr;
                imem_data <= pk_word;
                nxt_addr  <= nxt_addr + 1'b1;
                if (pk_err) begin
                    err <= 1'b1;
                end
            end
            if (imem_we) begin
                instr_count <= instr_count + 1'b1;
            end
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_RUN;
                        nxt_addr    <= base_addr;
                        instr_count <= '0;
                        err         <= 1'b0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (hs && (in_last || fill)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH reduced to 4).
// Expected words are hand-encoded constants.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 12;

    logic              clock;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [4:0]        op;
    logic [4:0]        rd;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        shamt;
    logic [4:0]        alu_op;
    logic [31:0]       imm;
    logic [31:0]       target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   instr_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] fill_word [4];
    logic [31:0] fill_addr [4];

    instr_encoder_loader #(
        .ADDR_W(ADDR_W),
        .DEPTH (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .op         (op),
        .rd         (rd),
        .rs         (rs),
        .rt         (rt),
        .shamt      (shamt),
        .alu_op     (alu_op),
        .imm        (imm),
        .target     (target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .instr_count(instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] o, input logic [4:0] d,
                         input logic [4:0] s, input logic [4:0] t,
                         input logic [31:0] im, input logic [31:0] tg,
                         input logic last);
        op       = o;
        rd       = d;
        rs       = s;
        rt       = t;
        shamt    = 5'd0;
        alu_op   = 5'd0;
        imm      = im;
        target   = tg;
        in_last  = last;
        in_valid = 1'b1;
    endtask

    task automatic wr(input string tag, input logic [31:0] a,
                      input logic [31:0] d);
        check({tag, "_we"}, {31'd0, imem_we}, 32'd1);
        check({tag, "_addr"}, {20'd0, imem_addr}, a);
        check({tag, "_data"}, imem_data, d);
    endtask

    task automatic kick(input logic [ADDR_W-1:0] b);
        start     = 1'b1;
        base_addr = b;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic idle_out(input string tag);
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_we"}, {31'd0, imem_we}, 32'd0);
        check({tag, "_addr"}, {20'd0, imem_addr}, 32'd0);
        check({tag, "_data"}, imem_data, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_cnt"}, {19'd0, instr_count}, 32'd0);
    endtask

    initial begin
        fill_word[0] = 32'h2840_0001;
        fill_word[1] = 32'h2880_0002;
        fill_word[2] = 32'h28C0_0003;
        fill_word[3] = 32'h2900_0004;
        fill_addr[0] = 32'hFFE;
        fill_addr[1] = 32'hFFF;
        fill_addr[2] = 32'h000;
        fill_addr[3] = 32'h001;

        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        op        = '0;
        rd        = '0;
        rs        = '0;
        rt        = '0;
        shamt     = '0;
        alu_op    = '0;
        imm       = '0;
        target    = '0;
        repeat (2) @(negedge clock);
        idle_out("rst");
        reset = 1'b0;
        @(negedge clock);

        // load 1: add, addi, bne, sw back to back
        kick(12'h010);
        check("l1_busy", {31'd0, busy}, 32'd1);
        check("l1_rdy", {31'd0, in_ready}, 32'd1);
        drive(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'd0, 1'b0);
        @(negedge clock);
        wr("add", 32'h010, 32'h00C2_2000);
        drive(5'd5, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        @(negedge clock);
        wr("addi", 32'h011, 32'h2841_FFFF);
        drive(5'd2, 5'd0, 5'd1, 5'd2, 32'd5, 32'd0, 1'b0);
        start     = 1'b1;
        base_addr = 12'h100;
        @(negedge clock);
        start = 1'b0;
        wr("bne", 32'h012, 32'h1044_0005);
        drive(5'd7, 5'd0, 5'd6, 5'd5, 32'd4, 32'd0, 1'b1);
        @(negedge clock);
        wr("sw", 32'h013, 32'h394C_0004);
        check("l1_drain_rdy", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clock);
        check("l1_done", {31'd0, done}, 32'd1);
        check("l1_busy0", {31'd0, busy}, 32'd0);
        check("l1_cnt", {19'd0, instr_count}, 32'd4);
        check("l1_we0", {31'd0, imem_we}, 32'd0);

        // load 2: single jal with in_last
        kick(12'h020);
        check("l2_done0", {31'd0, done}, 32'd0);
        drive(5'd3, 5'd0, 5'd0, 5'd0, 32'd0, 32'd100, 1'b1);
        @(negedge clock);
        wr("jal", 32'h020, 32'h1800_0064);
        check("jal_rdy", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clock);
        check("l2_done", {31'd0, done}, 32'd1);
        check("l2_cnt", {19'd0, instr_count}, 32'd1);

        // load 3: range errors
        kick(12'h030);
        check("l3_err0", {31'd0, err}, 32'd0);
        drive(5'd5, 5'd1, 5'd0, 5'd0, 32'd70000, 32'd0, 1'b0);
        @(negedge clock);
        wr("imm_err", 32'h030, 32'h0);
        check("imm_err_flag", {31'd0, err}, 32'd1);
        drive(5'd1, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0800_0000, 1'b1);
        @(negedge clock);
        wr("tgt_err", 32'h031, 32'h0);
        check("tgt_err_flag", {31'd0, err}, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clock);
        check("l3_done", {31'd0, done}, 32'd1);
        check("l3_cnt", {19'd0, instr_count}, 32'd2);
        check("l3_err_hold", {31'd0, err}, 32'd1);

        // load 4: fill DEPTH with address wrap
        kick(12'hFFE);
        check("l4_err0", {31'd0, err}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill%0d_rdy", i), {31'd0, in_ready}, 32'd1);
            drive(5'd5, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1), 32'd0, 1'b0);
            @(negedge clock);
            wr($sformatf("fill%0d", i), fill_addr[i], fill_word[i]);
        end
        check("fill_rdy0", {31'd0, in_ready}, 32'd0);
        drive(5'd5, 5'd9, 5'd0, 5'd0, 32'd9, 32'd0, 1'b0);
        @(negedge clock);
        check("fill_no5th", {31'd0, imem_we}, 32'd0);
        check("l4_done", {31'd0, done}, 32'd1);
        check("l4_cnt", {19'd0, instr_count}, 32'd4);
        in_valid = 1'b0;

        // load 5: reset in the cycle after a handshake
        kick(12'h040);
        drive(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'd0, 1'b0);
        @(posedge clock);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_mid_we", {31'd0, imem_we}, 32'd0);
        @(negedge clock);
        idle_out("rst_mid");
        reset = 1'b0;
        @(negedge clock);
        kick(12'h050);
        drive(5'd7, 5'd0, 5'd6, 5'd5, 32'd4, 32'd0, 1'b1);
        @(negedge clock);
        wr("reload", 32'h050, 32'h394C_0004);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clock);
        check("l5_done", {31'd0, done}, 32'd1);
        check("l5_cnt", {19'd0, instr_count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
